// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first,
// one bit per clock, with a start/busy/done handshake.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while busy=0 (the accepting edge loads a/b)
//   a, b    minuend / subtrahend, captured on the accepting edge
//   busy    high while a subtraction is in progress
//   done    one-cycle pulse when diff/borrow are updated
//   diff    a - b mod 2^WIDTH, held until the next completion
//   borrow  final borrow-out (1 iff a < b unsigned)
//   ovf     (only with SERIAL_SUBTRACTOR_SIGNED_OVF_EN) two's-complement
//           overflow of a - b, held with diff
//
// Optional feature macro: SERIAL_SUBTRACTOR_SIGNED_OVF_EN
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, bo, last, load;

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  logic             a_sign, b_sign;
`endif

  // Full-subtractor cell on the current LSBs and the held borrow.
  always_comb begin
    d    = sa[0] ^ sb[0] ^ br;
    bo   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last = (cnt == CW'(WIDTH - 1));
    load = (state == IDLE) && start;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // busy is the RUN state itself, so it drops together with the done pulse.
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        sa  <= a;
        sb  <= b;
        br  <= 1'b0;
        cnt <= '0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        a_sign <= a[WIDTH-1];
        b_sign <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        res <= {d, res[WIDTH-1:1]};
        br  <= bo;
        cnt <= cnt + CW'(1);
        if (last) begin
          // The final d bit lands in the MSB on this same edge.
          diff   <= {d, res[WIDTH-1:1]};
          borrow <= bo;
          done   <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
          ovf    <= (a_sign != b_sign) && (d != a_sign);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;
  int          pushed = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb_q.pop_front();
        check("diff", diff, e.d);
        check("borrow", borrow, e.br);
        check("done_latency_cycle", cyc, e.cyc);
        check("busy_low_with_done", busy, 0);
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        check("ovf", ovf, e.ov);
`endif
      end
    end
  end

  task automatic push(input logic [W-1:0] ed, input logic eb, input logic eo);
    sb_q.push_back('{ed, eb, eo, cyc + 1 + W});
    pushed++;
  endtask

  // Entered #1 after an edge with busy=0; leaves #1 after the completion edge
  // (the done cycle).
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input bit hold, input bit chk_prev, input logic [W-1:0] prev);
    a = ia;
    b = ib;
    start = 1'b1;
    push(ed, eb, eo);
    @(posedge clk); #1;
    check("busy_after_load", busy, 1);
    if (chk_prev) check("diff_hold_after_load", diff, prev);
    if (!hold) start = 1'b0;
    repeat (W - 1) @(posedge clk);
    #1;
    if (chk_prev) check("diff_hold_before_done", diff, prev);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    rst_n = 1'b1;
    idle(1);

    start_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 0, 0, '0);
    idle(1);
    check("done_single_pulse", done, 0);
    start_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, 0, '0);
    idle(1);
    start_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, 0, '0);
    idle(1);
    start_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0, '0);
    idle(1);

    // Starts during RUN cycles 2 and 5 must be ignored.
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    push(8'h05, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 1; i <= W; i++) begin
      if (i == 2 || i == 5) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    idle(2);

    // Back-to-back: start held, second operands presented in the done cycle.
    start_op(8'hC8, 8'h64, 8'h64, 1'b0, 1'b1, 1, 0, '0);
    start_op(8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 0, 1, 8'h64);
    idle(1);

    // Asynchronous abort mid-RUN.
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(W + 2);
    check("abort_busy_after_release", busy, 0);
    start_op(8'h03, 8'h01, 8'h02, 1'b0, 1'b0, 0, 0, '0);
    idle(1);

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    start_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0, '0);
    idle(1);
    start_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 0, '0);
    idle(1);
    start_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 0, '0);
    idle(1);
`endif

    idle(3);
    check("scoreboard_empty", sb_q.size(), 0);
    check("done_count", done_seen, pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses the full-subtractor counterpart of the team's gate-level full-adder cell: the same xor/nand-style datapath with the borrow held in a flop between cycles.
- Intended for area-constrained datapaths where a ripple array is too large.
- Simple start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when diff/borrow become valid
- diff  output  WIDTH  result a - b mod 2^WIDTH; held until the next completion
- borrow  output  1  final borrow-out; 1 iff a < b unsigned

Behaviour:
- Reset (async, rst_n=0): busy=0, done=0, diff=0, borrow=0; internal shift registers, borrow flop and bit counter cleared; FSM to IDLE. Reset asserted mid-operation aborts the operation with no done pulse. Release of reset is synchronous to clk.
- FSM states: IDLE, RUN. There is no separate DONE state; done is a registered flag.
- IDLE -> RUN:
  - Transition on a rising edge with start=1 (this is the load edge, E0).
  - Captures a and b into shift registers.
  - Clears the borrow flop and sets count=0.
  - busy goes 1 after E0.
- RUN, each edge E1..EWIDTH:
  - Bit cell: d = a0 ^ b0 ^ br; bo = (~a0 & b0) | (~(a0 ^ b0) & br).
  - a0 and b0 are the current LSBs of the shift registers.
  - Operand registers shift right; d shifts into the MSB of the internal result register; br <= bo; count increments.
- Completion edge EWIDTH:
  - diff <= final result register contents (including this edge's d bit).
  - borrow <= bo.
  - busy <= 0, done <= 1, FSM -> IDLE.
- Latency: done is high in the cycle following edge EWIDTH, i.e. WIDTH edges after the load edge. Throughput is one operation per WIDTH+1 cycles when start is held high.
- done is cleared on the next edge unconditionally.
- start while busy=1: ignored. No queuing, no effect on the current operation.
- start=1 in the cycle where done=1: accepted, since busy=0. The new load proceeds; the previous diff/borrow stay on the outputs until the new completion edge.
- diff and borrow never change except on a completion edge or reset. Intermediate bits are not visible.
- a and b are don't-care except on an accepting edge.
- Counter width: $clog2(WIDTH+1); no wrap is reachable.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_SIGNED_OVF_EN.
- When defined:
  - Adds output port ovf (output, 1 bit), reset value 0.
  - Sign bits of a and b are captured on the load edge.
  - On the completion edge, ovf <= (a_sign != b_sign) && (diff_msb != a_sign), where diff_msb is the final result MSB. This is two's-complement overflow of a - b.
  - ovf is held with diff.
- When not defined: the ovf port and the sign-capture flops do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=8: reset, then start with a=0x5A, b=0x23 -> busy=1 for 8 cycles; done pulses once exactly 8 edges after the load edge; diff=0x37, borrow=0; busy=0 with done.
- a=0x10, b=0x20 -> diff=0xF0, borrow=1. Then a=0x00, b=0x01 -> diff=0xFF, borrow=1. Then a=0x00, b=0x00 -> diff=0x00, borrow=0.
- Start a=0x09, b=0x04. Pulse start with a=0xFF, b=0x00 at cycles 2 and 5 of RUN -> both ignored; result diff=0x05, borrow=0, single done pulse.
- Back-to-back: start held high with a=0xC8, b=0x64, then a=0x01, b=0x02 presented in the done cycle:
  - First result diff=0x64, borrow=0.
  - Second load accepted in the done cycle; diff holds 0x64 until the second done.
  - Second result diff=0xFF, borrow=1.
- Start a=0xAA, b=0x55; drop rst_n asynchronously at RUN cycle 4 (mid-cycle, between edges) -> outputs 0 immediately; no done pulse; after release, a=0x03, b=0x01 yields diff=0x02 normally.
- With SERIAL_SUBTRACTOR_SIGNED_OVF_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.
